block_interleaver_stream: RTL

- Streaming, parametrised successor to the fixed 7x5 word-parallel interleaver.
- Accepts one W-bit element per cycle over a valid/ready handshake and buffers a block of N*SYMBOL_NUM elements in a ping-pong (two-bank) store.
- Emits each block permuted: row-in/column-out for interleave, or the inverse for deinterleave, selected per block.
- Sits between the Hamming encoder/decoder and the channel model; sustains one element per cycle with no inter-block bubbles.

---
 rtl/block_interleaver_stream.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/block_interleaver_stream.sv
// Streaming block interleaver: buffers L = N*SYMBOL_NUM elements per block in a
// two-bank store and emits each block row-in/column-out (mode 0) or the inverse (mode 1).
module block_interleaver_stream #(
  parameter int N          = 7,
  parameter int SYMBOL_NUM = 5,
  parameter int W          = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last
);
  localparam int L  = N * SYMBOL_NUM;
  localparam int CW = $clog2(L);

  localparam logic [CW-1:0] LAST = CW'(L - 1);
  localparam logic [CW-1:0] N_M1 = CW'(N - 1);
  localparam logic [CW-1:0] S_M1 = CW'(SYMBOL_NUM - 1);
  localparam logic [CW-1:0] N_C  = CW'(N);
  localparam logic [CW-1:0] S_C  = CW'(SYMBOL_NUM);

  if (N < 2 || SYMBOL_NUM < 2 || W < 1) begin : g_param_check
    $error("block_interleaver_stream: requires N >= 2, SYMBOL_NUM >= 2, W >= 1");
  end

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_e;

  bank_state_e   bank_q [2];
  bank_state_e   bank_d [2];
  logic          bank_mode_q [2];
  logic [W-1:0]  mem_q [2][L];

  logic          wr_bank_q, wr_bank_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic          rd_bank_q, rd_bank_d;
  logic [CW-1:0] rd_idx_q, rd_idx_d;
  logic [CW-1:0] rd_inner_q, rd_inner_d;
  logic [CW-1:0] rd_base_q, rd_base_d;
  logic [CW-1:0] rd_addr_q, rd_addr_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;

  logic          wr_fire, rd_fire, rd_mode;
  logic [CW-1:0] inner_max, stride;

  // Valid/ready: a transfer happens on a rising edge where valid && ready are both
  // high; once out_valid is raised it stays high, with out_data/out_last held,
  // until out_ready completes the transfer.
  always_comb begin
    wr_fire     = in_valid && in_ready_q;
    rd_fire     = out_valid_q && out_ready;
    rd_mode     = bank_mode_q[rd_bank_q];
    inner_max   = rd_mode ? N_M1 : S_M1;
    stride      = rd_mode ? S_C : N_C;
    bank_d      = bank_q;
    wr_bank_d   = wr_bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_bank_d   = rd_bank_q;
    rd_idx_d    = rd_idx_q;
    rd_inner_d  = rd_inner_q;
    rd_base_d   = rd_base_q;
    rd_addr_d   = rd_addr_q;

    if (wr_fire) begin
      if (wr_cnt_q == LAST) begin
        bank_d[wr_bank_q] = FULL;
        wr_cnt_d          = '0;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        bank_d[wr_bank_q] = FILLING;
        wr_cnt_d          = wr_cnt_q + 1'b1;
      end
    end

    // Inner counter walks one column with a fixed stride; on wrap the base steps by one.
    if (rd_fire) begin
      if (rd_idx_q == LAST) begin
        bank_d[rd_bank_q] = EMPTY;
        rd_bank_d         = ~rd_bank_q;
        rd_idx_d          = '0;
        rd_inner_d        = '0;
        rd_base_d         = '0;
        rd_addr_d         = '0;
      end else begin
        bank_d[rd_bank_q] = DRAINING;
        rd_idx_d          = rd_idx_q + 1'b1;
        if (rd_inner_q == inner_max) begin
          rd_inner_d = '0;
          rd_base_d  = rd_base_q + 1'b1;
          rd_addr_d  = rd_base_q + 1'b1;
        end else begin
          rd_inner_d = rd_inner_q + 1'b1;
          rd_addr_d  = rd_addr_q + stride;
        end
      end
    end

    in_ready_d  = (bank_d[wr_bank_d] == EMPTY) || (bank_d[wr_bank_d] == FILLING);
    out_valid_d = (bank_d[rd_bank_d] == FULL) || (bank_d[rd_bank_d] == DRAINING);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q[0]      <= EMPTY;
      bank_q[1]      <= EMPTY;
      bank_mode_q[0] <= 1'b0;
      bank_mode_q[1] <= 1'b0;
      wr_bank_q      <= 1'b0;
      wr_cnt_q       <= '0;
      rd_bank_q      <= 1'b0;
      rd_idx_q       <= '0;
      rd_inner_q     <= '0;
      rd_base_q      <= '0;
      rd_addr_q      <= '0;
      in_ready_q     <= 1'b0;
      out_valid_q    <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      wr_bank_q   <= wr_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_bank_q   <= rd_bank_d;
      rd_idx_q    <= rd_idx_d;
      rd_inner_q  <= rd_inner_d;
      rd_base_q   <= rd_base_d;
      rd_addr_q   <= rd_addr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      if (wr_fire && (wr_cnt_q == '0)) begin
        bank_mode_q[wr_bank_q] <= mode;
      end
    end
  end

  // Write and read never target the same bank: writes need EMPTY/FILLING, reads FULL/DRAINING.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_bank_q][wr_cnt_q] <= in_data;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_valid_q ? mem_q[rd_bank_q][rd_addr_q] : '0;
  assign out_last  = out_valid_q && (rd_idx_q == LAST);

endmodule
